ir_issue: RTL and testbench

//  Transmit side of the IR word stream. Queues transfer commands (source device, source address,

---
 rtl/ir_issue_if.sv | 39 +++
 rtl/ir_issue.sv | 148 ++++++++++++++
 tb/tb_ir_issue.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ir_issue_if.sv
// Handshake/bus bundle for the IR word issuer: command push side and IR word output side.
// o_cmd_count is only carried when IR_STATS_EN is defined.
interface ir_issue_if #(
    parameter int unsigned DW = 16
);
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [DW-1:0] i_src_dev;
    logic [DW-1:0] i_src_addr;
    logic [DW-1:0] i_tgt_dev;
    logic [DW-1:0] i_tgt_addr;
    logic          i_stall;
    logic          o_ir_en;
    logic [DW-1:0] o_ir;
    logic [1:0]    o_phase;
    logic          o_target_device_flag;
    logic          o_busy;
`ifdef IR_STATS_EN
    logic [15:0]   o_cmd_count;
`endif

    // Command sequencer / downstream side.
    modport master (
        output i_cmd_valid, i_src_dev, i_src_addr, i_tgt_dev, i_tgt_addr, i_stall,
        input  o_cmd_ready, o_ir_en, o_ir, o_phase, o_target_device_flag, o_busy
`ifdef IR_STATS_EN
        , input o_cmd_count
`endif
    );

    // Issuer side.
    modport slave (
        input  i_cmd_valid, i_src_dev, i_src_addr, i_tgt_dev, i_tgt_addr, i_stall,
        output o_cmd_ready, o_ir_en, o_ir, o_phase, o_target_device_flag, o_busy
`ifdef IR_STATS_EN
        , output o_cmd_count
`endif
    );
endinterface

// File: rtl/ir_issue.sv
// IR word issuer: queues transfer commands and serialises each as four IR words.
// Define IR_STATS_EN to add the completed-command counter o_cmd_count.
module ir_issue #(
    parameter int unsigned DW         = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic       clk,
    input logic       rst_n,
    ir_issue_if.slave bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 4 * DW;

    typedef enum logic [2:0] {
        StIdle,
        StSrcDev,
        StSrcAddr,
        StTgtDev,
        StTgtAddr
    } state_e;

    state_e        state_q, state_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] issue_q, issue_d;

    logic full, empty, push, pop, accept;

    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign push   = bus.i_cmd_valid & ~full;
    assign accept = (state_q != StIdle) & ~bus.i_stall;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StSrcDev;
                end
            end
            StSrcDev:  if (accept) state_d = StSrcAddr;
            StSrcAddr: if (accept) state_d = StTgtDev;
            StTgtDev:  if (accept) state_d = StTgtAddr;
            StTgtAddr: begin
                // Chain straight into the next command so o_ir_en stays continuous.
                if (accept) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = StSrcDev;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        issue_d  = issue_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            issue_d  = mem_q[rd_ptr_q];
        end
        if (push && !pop) count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            issue_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            issue_q  <= issue_d;
        end
    end

    // Queue storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.i_src_dev, bus.i_src_addr, bus.i_tgt_dev, bus.i_tgt_addr};
        end
    end

    always_comb begin
        bus.o_ir                 = '0;
        bus.o_phase              = 2'd0;
        bus.o_target_device_flag = 1'b0;
        unique case (state_q)
            StSrcDev: begin
                bus.o_ir    = issue_q[4*DW-1:3*DW];
                bus.o_phase = 2'd0;
            end
            StSrcAddr: begin
                bus.o_ir    = issue_q[3*DW-1:2*DW];
                bus.o_phase = 2'd1;
            end
            StTgtDev: begin
                bus.o_ir                 = issue_q[2*DW-1:DW];
                bus.o_phase              = 2'd2;
                bus.o_target_device_flag = 1'b1;
            end
            StTgtAddr: begin
                bus.o_ir    = issue_q[DW-1:0];
                bus.o_phase = 2'd3;
            end
            default: ;
        endcase
    end

    assign bus.o_ir_en     = (state_q != StIdle);
    assign bus.o_cmd_ready = ~full;
    assign bus.o_busy      = ~empty | (state_q != StIdle);

`ifdef IR_STATS_EN
    logic [15:0] cmd_count_q, cmd_count_d;

    always_comb begin
        cmd_count_d = cmd_count_q;
        if ((state_q == StTgtAddr) && accept) cmd_count_d = cmd_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cmd_count_q <= '0;
        else        cmd_count_q <= cmd_count_d;
    end

    assign bus.o_cmd_count = cmd_count_q;
`endif

endmodule

// File: tb/tb_ir_issue.sv
// Self-checking bench for ir_issue: a per-cycle vector table plus hand-written
// sequences for back-to-back issue, queue-full back-pressure and mid-command reset.
module tb_ir_issue;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ir_issue_if #(.DW(16)) bus ();

    ir_issue #(
        .DW        (16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // One row per cycle: inputs for that cycle and the outputs expected during it.
    typedef struct {
        logic        valid;
        logic [15:0] sd, sa, td, ta;
        logic        stall;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [21:0] ex(logic rdy, logic en, logic [15:0] ir, logic [1:0] ph,
                                       logic fl, logic busy);
        return {rdy, en, ir, ph, fl, busy};
    endfunction

    function automatic vec_t mkv(logic v, logic [15:0] sd, logic [15:0] sa, logic [15:0] td,
                                 logic [15:0] ta, logic st, logic [21:0] e);
        vec_t r;
        r.valid = v; r.sd = sd; r.sa = sa; r.td = td; r.ta = ta; r.stall = st; r.exp = e;
        return r;
    endfunction

    function automatic logic [21:0] obs();
        return {bus.o_cmd_ready, bus.o_ir_en, bus.o_ir, bus.o_phase,
                bus.o_target_device_flag, bus.o_busy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] sd, input logic [15:0] sa,
                         input logic [15:0] td, input logic [15:0] ta, input logic st);
        bus.i_cmd_valid = v;
        bus.i_src_dev   = sd;
        bus.i_src_addr  = sa;
        bus.i_tgt_dev   = td;
        bus.i_tgt_addr  = ta;
        bus.i_stall     = st;
    endtask

    logic [15:0] w2[8];
    logic [15:0] got[$];
    int          en_seen;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, '0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_state", 32'(obs()), 32'(ex(1, 0, 0, 0, 0, 0)));
`ifdef IR_STATS_EN
        check("reset_cmd_count", 32'(bus.o_cmd_count), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Single command, no stall.
        vecs.push_back(mkv(1, 16'h0001, 16'h0010, 16'h0002, 16'h0020, 0, ex(1, 0, 0, 0, 0, 0)));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, ex(1, 0, 16'h0000, 0, 0, 1)));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, ex(1, 1, 16'h0001, 0, 0, 1)));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, ex(1, 1, 16'h0010, 1, 0, 1)));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, ex(1, 1, 16'h0002, 2, 1, 1)));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, ex(1, 1, 16'h0020, 3, 0, 1)));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, ex(1, 0, 16'h0000, 0, 0, 0)));
        // Stall held 3 cycles in TGT_DEV; inputs scrambled after push must not leak through.
        vecs.push_back(mkv(1, 16'h000A, 16'h000B, 16'h000C, 16'h000D, 0, ex(1, 0, 0, 0, 0, 0)));
        vecs.push_back(mkv(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0,
                           ex(1, 0, 0, 0, 0, 1)));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, ex(1, 1, 16'h000A, 0, 0, 1)));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, ex(1, 1, 16'h000B, 1, 0, 1)));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, ex(1, 1, 16'h000C, 2, 1, 1)));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, ex(1, 1, 16'h000C, 2, 1, 1)));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 1, ex(1, 1, 16'h000C, 2, 1, 1)));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, ex(1, 1, 16'h000C, 2, 1, 1)));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, ex(1, 1, 16'h000D, 3, 0, 1)));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, ex(1, 0, 16'h0000, 0, 0, 0)));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].sd, vecs[i].sa, vecs[i].td, vecs[i].ta, vecs[i].stall);
            check($sformatf("vec_%0d", i), 32'(obs()), 32'(vecs[i].exp));
            @(negedge clk);
        end
`ifdef IR_STATS_EN
        check("stats_after_two", 32'(bus.o_cmd_count), 32'd2);
`endif

        // Two back-to-back commands: eight continuous words.
        w2[0] = 16'h0011; w2[1] = 16'h0012; w2[2] = 16'h0013; w2[3] = 16'h0014;
        w2[4] = 16'h0021; w2[5] = 16'h0022; w2[6] = 16'h0023; w2[7] = 16'h0024;
        drive(1, w2[0], w2[1], w2[2], w2[3], 0);
        @(negedge clk);
        drive(1, w2[4], w2[5], w2[6], w2[7], 0);
        @(negedge clk);
        drive(0, '0, '0, '0, '0, 0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("b2b_word_%0d", k), {15'd0, bus.o_ir_en, bus.o_ir}, {15'd0, 1'b1, w2[k]});
            @(negedge clk);
        end
        check("b2b_idle", {30'd0, bus.o_ir_en, bus.o_busy}, 32'd0);

        // Back-pressure: five pushes under stall fill the queue after one pop.
        for (int k = 1; k <= 5; k++) begin
            drive(1, 16'(k * 256), 16'(k * 256 + 1), 16'(k * 256 + 2), 16'(k * 256 + 3), 1);
            check($sformatf("full_ready_%0d", k), 32'(bus.o_cmd_ready), 32'd1);
            @(negedge clk);
        end
        drive(1, 16'h0600, 16'h0601, 16'h0602, 16'h0603, 1);
        check("full_ready_refuse_a", 32'(bus.o_cmd_ready), 32'd0);
        @(negedge clk);
        check("full_ready_refuse_b", 32'(bus.o_cmd_ready), 32'd0);
        @(negedge clk);
        drive(0, '0, '0, '0, '0, 0);
        for (int c = 0; c < 100; c++) begin
            if (got.size() >= 20 && !bus.o_busy) break;
            if (bus.o_ir_en) got.push_back(bus.o_ir);
            @(negedge clk);
        end
        check("full_word_count", 32'(got.size()), 32'd20);
        for (int i = 0; i < got.size() && i < 20; i++) begin
            check($sformatf("full_word_%0d", i), 32'(got[i]), 32'((i / 4 + 1) * 256 + i % 4));
        end
`ifdef IR_STATS_EN
        check("stats_before_reset", 32'(bus.o_cmd_count), 32'd9);
`endif

        // Reset during SRC_ADDR with two commands still queued.
        drive(1, 16'h0031, 16'h0032, 16'h0033, 16'h0034, 0);
        @(negedge clk);
        drive(1, 16'h0041, 16'h0042, 16'h0043, 16'h0044, 0);
        @(negedge clk);
        drive(1, 16'h0051, 16'h0052, 16'h0053, 16'h0054, 0);
        @(negedge clk);
        drive(0, '0, '0, '0, '0, 0);
        check("rst_pre_src_addr", {14'd0, bus.o_phase, bus.o_ir}, {14'd0, 2'd1, 16'h0032});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_after", 32'(obs()), 32'(ex(1, 0, 0, 0, 0, 0)));
        en_seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.o_ir_en) en_seen++;
            @(negedge clk);
        end
        check("rst_no_words", 32'(en_seen), 32'd0);

`ifdef IR_STATS_EN
        check("stats_cleared", 32'(bus.o_cmd_count), 32'd0);
        drive(1, 16'h0071, 16'h0072, 16'h0073, 16'h0074, 0);
        @(negedge clk);
        drive(0, '0, '0, '0, '0, 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!bus.o_busy) break;
        end
        check("stats_one_more", 32'(bus.o_cmd_count), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
